ntt_poly_loader: RTL and testbench
==================================

NTT_POLY_LOADER -- requirements
Module: ntt_poly_loader

Interface
REQ-001 SHALL have parameter N, default 256, meaning coefficients per polynomial.
REQ-002 SHALL have parameter Q, default 8380417, meaning Dilithium modulus.
REQ-003 SHALL have parameter BASE_ADDR, default 16'h0000, meaning first NTT memory address written.
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port s_valid  input  1  upstream coefficient valid.
REQ-007 SHALL have port s_ready  output  1  loader accepts the coefficient.
REQ-008 SHALL have port s_data  input  24  signed two's-complement coefficient.
REQ-009 SHALL have port load_mem  output  1  selects the NTT memory load port.
REQ-010 SHALL have port A_load  output  16  NTT memory write address.
REQ-011 SHALL have port D_load  output  24  NTT memory write data, in [0, Q-1].
REQ-012 SHALL have port WEB_load  output  1  active-low write enable.
REQ-013 SHALL have port start_NTT  output  1  one-cycle NTT start pulse.
REQ-014 SHALL have port done_NTT  input  1  NTT completion level/pulse from NTT_top.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse on NTT completion.
REQ-017 SHALL have port err  output  1  sticky out-of-range flag; cleared on the first beat of the next polynomial.

Function
REQ-018 SHALL implement states IDLE, LOAD, FLUSH, START, WAIT, DONE.
REQ-019 s_ready SHALL be 1 in IDLE and LOAD and 0 in all other states; a beat is accepted when s_valid and s_ready are both 1.
REQ-020 IDLE SHALL move to LOAD on an accepted beat; that beat is coefficient 0.
REQ-021 Each accepted beat k (0..N-1) SHALL register, on the same edge: A_load=BASE_ADDR+k, D_load=reduced value, WEB_load=0, load_mem=1.
REQ-022 A cycle in IDLE or LOAD with no accepted beat SHALL drive WEB_load=1 while load_mem holds its value.
REQ-023 Reduction: s_data in [0, Q-1] SHALL pass unchanged; s_data in [-(Q-1), -1] SHALL become s_data+Q; computation SHALL use 25-bit signed width.
REQ-024 Any other s_data SHALL write 0 and set err.
REQ-025 The beat counter SHALL be 9 bits; on accepting beat N-1 the state SHALL move to FLUSH and the counter SHALL clear to 0.
REQ-026 FLUSH (1 cycle) SHALL drive WEB_load=1 and load_mem=1 so the last write completes.
REQ-027 START (1 cycle) SHALL drive start_NTT=1 and load_mem=0.
REQ-028 WAIT SHALL hold all outputs idle and move to DONE on the first cycle done_NTT=1.
REQ-029 done_NTT asserted in IDLE, LOAD, FLUSH or START SHALL be ignored.
REQ-030 DONE (1 cycle) SHALL drive done=1, then return to IDLE.
REQ-031 Write-to-start latency: start_NTT SHALL rise exactly 2 cycles after the edge accepting beat N-1.

Reset
REQ-032 Reset SHALL force IDLE, counter=0, s_ready=0 during reset, load_mem=0, A_load=0, D_load=0, WEB_load=1, start_NTT=0, busy=0, done=0, err=0.
REQ-033 Reset mid-LOAD or mid-WAIT SHALL abandon the polynomial; the next accepted beat after release SHALL be coefficient 0.

Structure
REQ-034 Q, N, coefficient width (24) and address width (16) SHALL live in shared package dilithium_pkg.
REQ-035 Range check and reduction SHALL be one combinational sub-module ntt_coeff_reduce (in: 24-bit signed; out: 24-bit value, out_of_range).
REQ-036 All outputs of ntt_poly_loader SHALL be registered.

Verification
REQ-037 Ramp s_data=i, i=0..255, s_valid continuous -> writes A_load=i, D_load=i, WEB_load=0; start_NTT pulse 2 cycles after last beat; err=0.
REQ-038 s_data=-1, -8380416, 8380416 -> D_load=8380416, 1, 8380416; err=0.
REQ-039 s_data=8380417 or -8380417 at beat 5 -> D_load=0 at A_load=5, err=1 until next polynomial's first beat.
REQ-040 s_valid toggled randomly -> exactly 256 writes, consecutive addresses, WEB_load=1 in gap cycles.
REQ-041 done_NTT pulsed during LOAD, then 100 cycles after start -> first ignored; done pulses 1 cycle after second; busy falls with it.
REQ-042 rst asserted after beat 100 -> all outputs at reset values asynchronously; reload of 256 beats starts at A_load=0.

Source files
------------

// File: rtl/dilithium_pkg.sv
// Shared Dilithium NTT constants and the polynomial loader state encoding.
package dilithium_pkg;

  localparam int unsigned DilN   = 256;      // coefficients per polynomial
  localparam int unsigned DilQ   = 8380417;  // Dilithium modulus
  localparam int unsigned CoeffW = 24;       // coefficient / memory data width
  localparam int unsigned AddrW  = 16;       // NTT memory address width
  localparam int unsigned CntW   = 9;        // beat counter width

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFlush,
    StStart,
    StWait,
    StDone
  } loader_state_e;

endpackage

// File: rtl/ntt_coeff_reduce.sv
// Maps a signed coefficient into [0, Q-1]; values outside [-(Q-1), Q-1] yield 0 and a flag.
module ntt_coeff_reduce
  import dilithium_pkg::*;
#(
  parameter int unsigned Q = DilQ
) (
  input  logic [CoeffW-1:0] coeff_i,
  output logic [CoeffW-1:0] coeff_o,
  output logic              out_of_range_o
);

  localparam logic signed [CoeffW:0] QExt = (CoeffW + 1)'(Q);

  logic signed [CoeffW:0] coeff_ext;
  logic signed [CoeffW:0] coeff_plus_q;

  assign coeff_ext    = $signed({coeff_i[CoeffW-1], coeff_i});
  assign coeff_plus_q = coeff_ext + QExt;

  // Range check and conditional add of Q, all in 25-bit signed arithmetic.
  always_comb begin
    coeff_o        = '0;
    out_of_range_o = 1'b0;
    if (!coeff_ext[CoeffW] && (coeff_ext < QExt)) begin
      coeff_o = coeff_ext[CoeffW-1:0];
    end else if (coeff_ext[CoeffW] && !coeff_plus_q[CoeffW] && (coeff_plus_q != '0)) begin
      // A negative input with x + Q >= 1 means x >= -(Q-1).
      coeff_o = coeff_plus_q[CoeffW-1:0];
    end else begin
      out_of_range_o = 1'b1;
    end
  end

endmodule

// File: rtl/ntt_poly_loader.sv
// Streams N coefficients into the NTT memory load port, then starts the NTT and waits
// for its completion. All outputs are registered.
module ntt_poly_loader
  import dilithium_pkg::*;
#(
  parameter int unsigned      N         = DilN,
  parameter int unsigned      Q         = DilQ,
  parameter logic [AddrW-1:0] BASE_ADDR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [CoeffW-1:0] s_data,
  output logic              load_mem,
  output logic [AddrW-1:0]  A_load,
  output logic [CoeffW-1:0] D_load,
  output logic              WEB_load,
  output logic              start_NTT,
  input  logic              done_NTT,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [CntW-1:0] LastBeat = CntW'(N - 1);

  loader_state_e     state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              load_mem_q, load_mem_d;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic [CoeffW-1:0] data_q, data_d;
  logic              web_q, web_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic [CoeffW-1:0] coeff_red;
  logic              coeff_oor;

  assign accept = s_valid & ready_q;

  ntt_coeff_reduce #(
    .Q(Q)
  ) u_reduce (
    .coeff_i       (s_data),
    .coeff_o       (coeff_red),
    .out_of_range_o(coeff_oor)
  );

  // Next-state and next-output decode; output registers follow the current state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_mem_d = load_mem_q;
    addr_d     = addr_q;
    data_d     = data_q;
    web_d      = 1'b1;
    start_d    = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;

    unique case (state_q)
      StIdle, StLoad: begin
        if (accept) begin
          addr_d     = BASE_ADDR + AddrW'(cnt_q);
          data_d     = coeff_red;
          web_d      = 1'b0;
          load_mem_d = 1'b1;
          // Beat 0 starts a fresh polynomial, so the sticky flag restarts there.
          err_d      = (cnt_q == '0) ? coeff_oor : (err_q | coeff_oor);
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = StFlush;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StLoad;
          end
        end
      end
      StFlush: begin
        load_mem_d = 1'b1;
        state_d    = StStart;
      end
      StStart: begin
        start_d    = 1'b1;
        load_mem_d = 1'b0;
        state_d    = StWait;
      end
      StWait: begin
        if (done_NTT) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Handshake and busy track the state itself so acceptance never lags.
    ready_d = (state_d == StIdle) || (state_d == StLoad);
    busy_d  = (state_d != StIdle);
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      load_mem_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      web_q      <= 1'b1;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      load_mem_q <= load_mem_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      web_q      <= web_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign s_ready   = ready_q;
  assign load_mem  = load_mem_q;
  assign A_load    = addr_q;
  assign D_load    = data_q;
  assign WEB_load  = web_q;
  assign start_NTT = start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ntt_poly_loader.sv
// Directed bench for ntt_poly_loader.
module tb_ntt_poly_loader;

  localparam int N = 256;
  localparam int Q = 8380417;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        load_mem;
  logic [15:0] A_load;
  logic [23:0] D_load;
  logic        WEB_load;
  logic        start_NTT;
  logic        done_NTT;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int coeffs[N];
  int exp_d[N];

  always #5 clk = ~clk;

  ntt_poly_loader #(
    .N        (N),
    .Q        (Q),
    .BASE_ADDR(16'h0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .load_mem (load_mem),
    .A_load   (A_load),
    .D_load   (D_load),
    .WEB_load (WEB_load),
    .start_NTT(start_NTT),
    .done_NTT (done_NTT),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_s_ready"}, 32'(s_ready), 0);
    check_val({tag, "_load_mem"}, 32'(load_mem), 0);
    check_val({tag, "_A_load"}, 32'(A_load), 0);
    check_val({tag, "_D_load"}, 32'(D_load), 0);
    check_val({tag, "_WEB_load"}, 32'(WEB_load), 1);
    check_val({tag, "_start_NTT"}, 32'(start_NTT), 0);
    check_val({tag, "_busy"}, 32'(busy), 0);
    check_val({tag, "_done"}, 32'(done), 0);
    check_val({tag, "_err"}, 32'(err), 0);
  endtask

  // Drives coeffs[] as one polynomial; counts every write or gap cycle that disagrees.
  task automatic load_poly(input bit gaps, input int early_done, output int bad,
                           output logic err_first);
    int k      = 0;
    int cycles = 0;
    bit acc;
    bad       = 0;
    err_first = 1'b0;
    while (k < N && cycles < 4 * N) begin
      s_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data   = 24'(coeffs[k]);
      done_NTT = (k == early_done);
      if (s_ready !== 1'b1) bad++;
      acc = s_valid;
      tick();
      if (acc) begin
        if (WEB_load !== 1'b0 || load_mem !== 1'b1 || A_load !== 16'(k) ||
            D_load !== 24'(exp_d[k])) bad++;
        if (k == 0) err_first = err;
        k++;
      end else if (WEB_load !== 1'b1) begin
        bad++;
      end
      cycles++;
    end
    s_valid  = 1'b0;
    done_NTT = 1'b0;
    if (k < N) bad++;
  endtask

  // Called just after the edge that accepted the last beat.
  task automatic finish_poly(input string tag, input int delay);
    int bad = 0;
    check_val({tag, "_ready_low"}, 32'(s_ready), 0);
    check_val({tag, "_busy_load"}, 32'(busy), 1);
    tick();
    check_val({tag, "_flush_web"}, 32'(WEB_load), 1);
    check_val({tag, "_flush_load_mem"}, 32'(load_mem), 1);
    check_val({tag, "_flush_start"}, 32'(start_NTT), 0);
    tick();
    check_val({tag, "_start_pulse"}, 32'(start_NTT), 1);
    check_val({tag, "_start_load_mem"}, 32'(load_mem), 0);
    repeat (delay) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b1 || start_NTT !== 1'b0 || WEB_load !== 1'b1) bad++;
    end
    check_val({tag, "_wait_idle"}, 32'(bad), 0);
    done_NTT = 1'b1;
    tick();
    done_NTT = 1'b0;
    check_val({tag, "_done_not_yet"}, 32'(done), 0);
    check_val({tag, "_busy_wait"}, 32'(busy), 1);
    tick();
    check_val({tag, "_done_pulse"}, 32'(done), 1);
    check_val({tag, "_busy_fall"}, 32'(busy), 0);
    check_val({tag, "_ready_back"}, 32'(s_ready), 1);
    tick();
    check_val({tag, "_done_end"}, 32'(done), 0);
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < N; i++) begin
      coeffs[i] = i;
      exp_d[i]  = i;
    end
  endtask

  initial begin
    int   bad;
    logic ef;
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    done_NTT = 1'b0;
    #12;
    check_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    check_val("idle_ready", 32'(s_ready), 1);
    check_val("idle_busy", 32'(busy), 0);

    // Plain ramp, continuous valid.
    fill_ramp();
    load_poly(1'b0, -1, bad, ef);
    check_val("ramp_writes", 32'(bad), 0);
    check_val("ramp_err", 32'(err), 0);
    finish_poly("ramp", 3);

    // Negative values and the extremes of the valid range.
    for (int i = 0; i < N; i++) begin
      coeffs[i] = -i;
      exp_d[i]  = (i == 0) ? 0 : Q - i;
    end
    coeffs[0] = -1;       exp_d[0] = 8380416;
    coeffs[1] = -8380416; exp_d[1] = 1;
    coeffs[2] = 8380416;  exp_d[2] = 8380416;
    load_poly(1'b0, -1, bad, ef);
    check_val("neg_writes", 32'(bad), 0);
    check_val("neg_err", 32'(err), 0);
    finish_poly("neg", 0);

    // +Q at beat 5: written as 0, err sticks through the NTT.
    fill_ramp();
    coeffs[5] = 8380417;
    exp_d[5]  = 0;
    load_poly(1'b0, -1, bad, ef);
    check_val("ovf_writes", 32'(bad), 0);
    check_val("ovf_err_first", 32'(ef), 0);
    check_val("ovf_err_set", 32'(err), 1);
    finish_poly("ovf", 5);
    check_val("ovf_err_sticky", 32'(err), 1);

    // -Q at beat 5 with random gaps and a stray done_NTT during LOAD.
    fill_ramp();
    coeffs[5] = -8380417;
    exp_d[5]  = 0;
    load_poly(1'b1, 50, bad, ef);
    check_val("gap_writes", 32'(bad), 0);
    check_val("gap_err_cleared", 32'(ef), 0);
    check_val("gap_err_set", 32'(err), 1);
    finish_poly("gap", 98);

    // Abort after beat 100, then a full reload from address 0.
    fill_ramp();
    for (int i = 0; i <= 100; i++) begin
      s_valid = 1'b1;
      s_data  = 24'(i);
      tick();
    end
    check_val("abort_pre_addr", 32'(A_load), 100);
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals("abort");
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    load_poly(1'b0, -1, bad, ef);
    check_val("reload_writes", 32'(bad), 0);
    check_val("reload_err", 32'(err), 0);
    finish_poly("reload", 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
